mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Consumer end of the execute-stage result interface (ealu/ern/eb plus control).
- Contains the EX/MEM pipeline register, a word-organised data memory with byte/half/word access, and the MEM/WB pipeline register.
- Produces the write-back bus (wrn, wwreg, wdi) for the register file.
- Exposes MEM-stage values for the forwarding and hazard logic.

Parameters:
- ADDR_W, 8, word-address width; memory holds 2**ADDR_W 32-bit words; byte address bits [ADDR_W+1:2] select the word.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous reset, active-low
- ealu  in  32  EXE result; load/store byte address
- eb  in  32  store data (rt value)
- ern  in  5  destination register
- ewreg  in  1  EXE instruction writes a register
- em2reg  in  1  EXE instruction is a load
- ewmem  in  1  EXE instruction is a store
- emsize  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- eunsigned  in  1  load zero-extends (1) or sign-extends (0)
- malu  out  32  EX/MEM registered ALU result (forwarding)
- mrn  out  5  EX/MEM registered destination
- mwreg  out  1  EX/MEM registered write enable
- mm2reg  out  1  EX/MEM registered load flag (load-use hazard detection)
- mexc  out  1  misaligned access in MEM stage (combinational from EX/MEM registers)
- wrn  out  5  MEM/WB destination register
- wwreg  out  1  MEM/WB register-file write enable
- wdi  out  32  write-back data

Behaviour:
- Reset (resetn low, asynchronous):
  - All EX/MEM and MEM/WB register bits go to 0 immediately.
  - Outputs: malu=0, mrn=0, mwreg=0, mm2reg=0, wrn=0, wwreg=0, wdi=0, mexc=0.
  - Data memory contents are not reset.
  - A store sitting in MEM when reset asserts is not performed.
- EX/MEM register: captures ealu, eb, ern, ewreg, em2reg, ewmem, emsize, eunsigned on every rising edge. No stall or flush; upstream inserts bubbles by driving ewreg=ewmem=0.
- Alignment, evaluated in MEM from the registered address and size:
  - Half access is misaligned if malu[0]=1.
  - Word access (size 10 or 11) is misaligned if malu[1:0]!=00.
  - Byte access is never misaligned.
  - mexc = (mm2reg | mwmem) & misaligned.
- Store:
  - Takes effect on the rising edge that ends the MEM cycle, when mwmem=1 and the access is aligned.
  - Byte store writes lane malu[1:0] with mb[7:0].
  - Half store writes lanes {1,0} or {3,2} per malu[1] with mb[15:0].
  - Word store writes all lanes.
  - Little-endian: lane 0 = bits [7:0].
  - Misaligned store writes nothing.
- Load read: combinational read of the indexed word during MEM.
  - Byte lane or half selected by address; sign- or zero-extended per the registered eunsigned.
  - Misaligned load returns 0.
- Store-to-load ordering: a store in MEM at cycle t followed by a load of the same word in MEM at cycle t+1 returns the updated data. No bypass is needed because the write completes at the edge.
- MEM/WB register, captured every rising edge:
  - wrn <= mrn.
  - wwreg <= mwreg & ~(mm2reg & misaligned).
  - wdi <= mm2reg ? load_data : malu.
- Latency: an EXE input presented in cycle t appears on malu/mrn in t+1 and on wdi/wrn/wwreg in t+2.
- Address bits above ADDR_W+1 are ignored; the address wraps modulo memory size.
- Simultaneous ewreg and ewmem is legal: the store is performed and the register write passes through.

Test Plan:
- Reset mid-stream: drive a store plus ALU ops, then assert resetn=0 between edges → all outputs read 0 immediately; after release, the pending store is absent from memory.
- ALU pass-through: ealu=0x0000_1234, ern=5, ewreg=1, em2reg=0 → cycle+1 malu=0x1234, mrn=5; cycle+2 wdi=0x1234, wrn=5, wwreg=1.
- Word store then word load: sw 0xDEAD_BEEF at address 0x10, next cycle lw from 0x10 → wdi=0xDEAD_BEEF two cycles after the load.
- Byte and half stores/loads:
  - After the previous word, sb 0x80 at 0x11.
  - lb 0x11 → wdi=0xFFFF_FF80.
  - lbu 0x11 → wdi=0x0000_0080.
  - lh 0x12 → wdi=0xFFFF_DEAD.
  - lhu 0x10 → wdi=0x0000_80EF.
- Misaligned access:
  - sw at 0x13 → mexc=1 in MEM; memory word 0x10 unchanged.
  - lw from 0x13 → mexc=1, wwreg=0, wdi=0.
  - lh at 0x11 → mexc=1.
  - lb at 0x13 → mexc=0.
- Bubble and wrap: ewreg=ewmem=0 → wwreg=0, memory untouched. sw to byte address 0x400 with ADDR_W=8 → overwrites word index 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM pipeline register, byte-addressable word memory with
// byte/half/word access, and MEM/WB pipeline register driving the write-back
// bus. MEM-stage values are exposed for forwarding and hazard detection.
module mem_wb_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [1:0]  emsize,
  input  logic        eunsigned,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mexc,
  output logic [4:0]  wrn,
  output logic        wwreg,
  output logic [31:0] wdi
);

  localparam int DEPTH = 1 << ADDR_W;

  // EX/MEM register state
  logic [31:0] malu_r;
  logic [31:0] mb_r;
  logic [4:0]  mrn_r;
  logic        mwreg_r;
  logic        mm2reg_r;
  logic        mwmem_r;
  logic [1:0]  msize_r;
  logic        munsigned_r;

  // MEM/WB register state
  logic [4:0]  wrn_r;
  logic        wwreg_r;
  logic [31:0] wdi_r;

  // Data memory (not reset)
  logic [31:0] dmem_r [DEPTH];

  // MEM-stage combinational values
  logic [ADDR_W-1:0] widx_s;
  logic [1:0]        boff_s;
  logic              mis_s;
  logic [3:0]        lane_we_s;
  logic [31:0]       st_data_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       ld_data_s;

  // Misalignment: halves need an even address, words a multiple of four.
  function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] lane_mask_f(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store data replicated so every lane carries the bytes it may receive.
  function automatic logic [31:0] store_data_f(input logic [1:0] size, input logic [31:0] b);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{b[7:0]}};
      2'b01:   d = {2{b[15:0]}};
      default: d = b;
    endcase
    return d;
  endfunction

  // Extract and extend the addressed byte/half from a memory word.
  function automatic logic [31:0] load_extract_f(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // EX/MEM register: captures the execute result every cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      malu_r      <= 32'h0000_0000;
      mb_r        <= 32'h0000_0000;
      mrn_r       <= 5'd0;
      mwreg_r     <= 1'b0;
      mm2reg_r    <= 1'b0;
      mwmem_r     <= 1'b0;
      msize_r     <= 2'b00;
      munsigned_r <= 1'b0;
    end else begin
      malu_r      <= ealu;
      mb_r        <= eb;
      mrn_r       <= ern;
      mwreg_r     <= ewreg;
      mm2reg_r    <= em2reg;
      mwmem_r     <= ewmem;
      msize_r     <= emsize;
      munsigned_r <= eunsigned;
    end
  end

  // MEM-stage address decode, alignment, store lane enables and load data
  always_comb begin
    widx_s    = malu_r[ADDR_W+1:2];
    boff_s    = malu_r[1:0];
    mis_s     = misaligned_f(msize_r, boff_s);
    st_data_s = store_data_f(msize_r, mb_r);
    rd_word_s = dmem_r[widx_s];
    if (mwmem_r && !mis_s) begin
      lane_we_s = lane_mask_f(msize_r, boff_s);
    end else begin
      lane_we_s = 4'b0000;
    end
    if (mis_s) begin
      ld_data_s = 32'h0000_0000;
    end else begin
      ld_data_s = load_extract_f(rd_word_s, msize_r, boff_s, munsigned_r);
    end
  end

  // Data memory write: merge enabled byte lanes at the end of the MEM cycle
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we_s[i]) begin
        dmem_r[widx_s][8*i +: 8] <= st_data_s[8*i +: 8];
      end
    end
  end

  // MEM/WB register: select write-back data, suppress faulting load writes
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wrn_r   <= 5'd0;
      wwreg_r <= 1'b0;
      wdi_r   <= 32'h0000_0000;
    end else begin
      wrn_r   <= mrn_r;
      wwreg_r <= mwreg_r & ~(mm2reg_r & mis_s);
      wdi_r   <= mm2reg_r ? ld_data_s : malu_r;
    end
  end

  assign malu   = malu_r;
  assign mrn    = mrn_r;
  assign mwreg  = mwreg_r;
  assign mm2reg = mm2reg_r;
  assign mexc   = (mm2reg_r | mwmem_r) & mis_s;
  assign wrn    = wrn_r;
  assign wwreg  = wwreg_r;
  assign wdi    = wdi_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed stimulus for mem_wb_stage, checked
// every cycle against a byte-array memory model plus hand-computed literals.
module tb_mem_wb_stage;

  localparam int ADDR_W = 8;
  localparam int MEMB   = 4 << ADDR_W;

  logic        clock  = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] ealu   = 32'h0;
  logic [31:0] eb     = 32'h0;
  logic [4:0]  ern    = 5'd0;
  logic        ewreg  = 1'b0;
  logic        em2reg = 1'b0;
  logic        ewmem  = 1'b0;
  logic [1:0]  emsize = 2'b00;
  logic        eunsigned = 1'b0;
  logic [31:0] malu;
  logic [4:0]  mrn;
  logic        mwreg;
  logic        mm2reg;
  logic        mexc;
  logic [4:0]  wrn;
  logic        wwreg;
  logic [31:0] wdi;

  mem_wb_stage #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .resetn(resetn), .ealu(ealu), .eb(eb), .ern(ern),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .emsize(emsize),
    .eunsigned(eunsigned), .malu(malu), .mrn(mrn), .mwreg(mwreg),
    .mm2reg(mm2reg), .mexc(mexc), .wrn(wrn), .wwreg(wwreg), .wdi(wdi)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [1:0]  size;
    logic        uns;
  } txn_t;

  // Reference model state
  txn_t        mq = '0;
  logic [7:0]  mem_m [MEMB];
  logic [31:0] exp_wdi   = 32'h0;
  logic [4:0]  exp_wrn   = 5'd0;
  logic        exp_wwreg = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic mis_m(input txn_t t);
    return (int'(t.alu[1:0]) % nbytes(t.size)) != 0;
  endfunction

  function automatic int baddr(input txn_t t, input int k);
    return (int'(t.alu[ADDR_W+1:0]) + k) % MEMB;
  endfunction

  function automatic logic [31:0] load_m(input txn_t t);
    int n;
    logic [31:0] v;
    n = nbytes(t.size);
    v = 32'h0;
    if (mis_m(t)) return 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mem_m[baddr(t, k)]) << (8 * k));
    if (!t.uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic txn_t mk(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                              input logic wreg, input logic m2reg, input logic wmem,
                              input logic [1:0] size, input logic uns);
    txn_t t;
    t.alu = alu; t.b = b; t.rn = rn; t.wreg = wreg; t.m2reg = m2reg;
    t.wmem = wmem; t.size = size; t.uns = uns;
    return t;
  endfunction

  function automatic txn_t st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] size);
    return mk(a, d, 5'd0, 1'b0, 1'b0, 1'b1, size, 1'b0);
  endfunction

  function automatic txn_t ld(input logic [31:0] a, input logic [4:0] rn, input logic [1:0] size,
                              input logic uns);
    return mk(a, 32'h0, rn, 1'b1, 1'b1, 1'b0, size, uns);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one instruction at the falling edge; return just after it enters MEM.
  task automatic step(input txn_t t);
    @(negedge clock);
    ealu = t.alu; eb = t.b; ern = t.rn; ewreg = t.wreg; em2reg = t.m2reg;
    ewmem = t.wmem; emsize = t.size; eunsigned = t.uns;
    @(posedge clock);
    #1;
  endtask

  // Model: retire the MEM instruction into write-back and apply its store
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mq        <= '0;
      exp_wdi   <= 32'h0;
      exp_wrn   <= 5'd0;
      exp_wwreg <= 1'b0;
    end else begin
      exp_wrn   <= mq.rn;
      exp_wwreg <= mq.wreg && !(mq.m2reg && mis_m(mq));
      exp_wdi   <= mq.m2reg ? load_m(mq) : mq.alu;
      if (mq.wmem && !mis_m(mq)) begin
        for (int k = 0; k < nbytes(mq.size); k++) mem_m[baddr(mq, k)] <= mq.b[8*k +: 8];
      end
      mq <= mk(ealu, eb, ern, ewreg, em2reg, ewmem, emsize, eunsigned);
    end
  end

  // Compare every output against the model once per cycle
  always @(negedge clock) begin
    chk("malu", malu, mq.alu);
    chk("mrn", 32'(mrn), 32'(mq.rn));
    chk("mwreg", 32'(mwreg), 32'(mq.wreg));
    chk("mm2reg", 32'(mm2reg), 32'(mq.m2reg));
    chk("mexc", 32'(mexc), 32'((mq.m2reg | mq.wmem) & mis_m(mq)));
    chk("wrn", 32'(wrn), 32'(exp_wrn));
    chk("wwreg", 32'(wwreg), 32'(exp_wwreg));
    chk("wdi", wdi, exp_wdi);
  end

  initial begin
    txn_t nop;
    txn_t t;
    int   kind;
    nop = '0;

    // Power-on reset
    #1 resetn = 1'b0;
    #2;
    chk("rst_malu", malu, 32'h0);
    chk("rst_wdi", wdi, 32'h0);
    chk("rst_wwreg", 32'(wwreg), 32'h0);
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;

    // Fill every memory word so all later loads are defined
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      step(st(($urandom & 32'hFFFF_FC00) | (32'(i) << 2), $urandom, 2'b10));
    end

    // ALU pass-through
    step(mk(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0));
    chk("pass_malu", malu, 32'h0000_1234);
    chk("pass_mrn", 32'(mrn), 32'd5);
    step(nop);
    chk("pass_wdi", wdi, 32'h0000_1234);
    chk("pass_wrn", 32'(wrn), 32'd5);
    chk("pass_wwreg", 32'(wwreg), 32'd1);

    // Word store then word load
    step(st(32'h10, 32'hDEAD_BEEF, 2'b10));
    step(ld(32'h10, 5'd8, 2'b10, 1'b0));
    step(nop);
    chk("sw_lw", wdi, 32'hDEAD_BEEF);

    // Byte and half accesses
    step(st(32'h11, 32'h0000_0080, 2'b00));
    step(ld(32'h11, 5'd1, 2'b00, 1'b0));
    step(ld(32'h11, 5'd2, 2'b00, 1'b1));
    chk("lb", wdi, 32'hFFFF_FF80);
    step(ld(32'h12, 5'd3, 2'b01, 1'b0));
    chk("lbu", wdi, 32'h0000_0080);
    step(ld(32'h10, 5'd4, 2'b01, 1'b1));
    chk("lh", wdi, 32'hFFFF_DEAD);
    step(nop);
    chk("lhu", wdi, 32'h0000_80EF);

    // Misaligned accesses
    step(st(32'h13, 32'h1111_1111, 2'b10));
    chk("sw_mis_mexc", 32'(mexc), 32'd1);
    step(ld(32'h13, 5'd9, 2'b10, 1'b0));
    chk("lw_mis_mexc", 32'(mexc), 32'd1);
    step(ld(32'h11, 5'd6, 2'b01, 1'b0));
    chk("lh_mis_mexc", 32'(mexc), 32'd1);
    chk("lw_mis_wwreg", 32'(wwreg), 32'd0);
    chk("lw_mis_wdi", wdi, 32'h0);
    step(ld(32'h13, 5'd7, 2'b00, 1'b0));
    chk("lb_ok_mexc", 32'(mexc), 32'd0);
    step(ld(32'h10, 5'd10, 2'b10, 1'b0));
    step(nop);
    chk("mis_sw_nowrite", wdi, 32'hDEAD_80EF);

    // Address wrap onto word 0
    step(st(32'h400, 32'hCAFE_F00D, 2'b10));
    step(ld(32'h0, 5'd11, 2'b10, 1'b0));
    step(nop);
    chk("wrap", wdi, 32'hCAFE_F00D);

    // Store with register write passes the ALU value through
    step(mk(32'h24, 32'h55, 5'd3, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0));
    step(nop);
    chk("st_wreg_wdi", wdi, 32'h24);
    chk("st_wreg_wwreg", 32'(wwreg), 32'd1);

    // Reset mid-stream: pending store must be dropped
    step(st(32'h20, 32'h0BAD_F00D, 2'b10));
    step(st(32'h20, 32'h1234_5678, 2'b10));
    #2;
    resetn = 1'b0;
    ealu = 32'h0; eb = 32'h0; ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0;
    ewmem = 1'b0; emsize = 2'b00; eunsigned = 1'b0;
    #1;
    chk("mrst_malu", malu, 32'h0);
    chk("mrst_mrn", 32'(mrn), 32'h0);
    chk("mrst_mwreg", 32'(mwreg), 32'h0);
    chk("mrst_mm2reg", 32'(mm2reg), 32'h0);
    chk("mrst_mexc", 32'(mexc), 32'h0);
    chk("mrst_wrn", 32'(wrn), 32'h0);
    chk("mrst_wwreg", 32'(wwreg), 32'h0);
    chk("mrst_wdi", wdi, 32'h0);
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;
    step(ld(32'h20, 5'd12, 2'b10, 1'b0));
    step(nop);
    chk("rst_store_dropped", wdi, 32'h0BAD_F00D);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      kind = $urandom_range(0, 3);
      t.alu   = $urandom;
      if ($urandom_range(0, 1) == 0) t.alu[1:0] = 2'b00;
      t.b     = $urandom;
      t.rn    = 5'($urandom);
      t.size  = 2'($urandom);
      t.uns   = 1'($urandom);
      t.m2reg = (kind == 1);
      t.wmem  = (kind == 2) || (kind == 0 && $urandom_range(0, 3) == 0);
      t.wreg  = (kind == 3) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      step(t);
    end
    step(nop);
    step(nop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
